// File: rtl/seven_seg_decoder.sv
// Loop-back monitor for a seven-segment drive bus: debounces the sampled pattern,
// decodes it to a hex digit plus decimal point, and reports each new stable pattern once.
module seven_seg_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  output logic [4:0] value_o,
  output logic       blank_o,
  output logic       invalid_o,
  output logic       ambig_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       overrun_o,
  input  logic       clr_i
);

  typedef enum logic {TRACK, HOLD} state_t;

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

  state_t           state, state_next;
  logic [7:0]       seg_q;
  logic [7:0]       last_pat;
  logic             have_last;
  logic [CNT_W-1:0] cnt;
  logic             stable;
  logic             moving;
  logic             load;
  logic             ack;

  logic [3:0]       dec_digit;
  logic             dec_blank;
  logic             dec_invalid;
  logic             dec_ambig;

  assign moving = (seg_in != seg_q);
  assign stable = (cnt == STABLE_MAX);

  // 7C is shared by 6 and B; it always resolves to 6 with the ambiguity flagged.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    dec_digit   = 4'h0;
    dec_blank   = 1'b0;
    dec_invalid = 1'b0;
    dec_ambig   = 1'b0;
    case (seg_q[6:0])
      7'h3F: dec_digit = 4'h0;
      7'h06: dec_digit = 4'h1;
      7'h5B: dec_digit = 4'h2;
      7'h4F: dec_digit = 4'h3;
      7'h66: dec_digit = 4'h4;
      7'h6D: dec_digit = 4'h5;
      7'h7C: begin dec_digit = 4'h6; dec_ambig = 1'b1; end
      7'h07: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h67: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h39: dec_digit = 4'hC;
      7'h5E: dec_digit = 4'hD;
      7'h79: dec_digit = 4'hE;
      7'h71: dec_digit = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_invalid = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    ack        = 1'b0;
    case (state)
      TRACK: begin
        if (stable && (!have_last || seg_q != last_pat)) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (valid_o && ready_i) begin
          ack        = 1'b1;
          state_next = TRACK;
        end
      end
      default: state_next = TRACK;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state     <= TRACK;
      seg_q     <= '0;
      cnt       <= '0;
      last_pat  <= '0;
      have_last <= 1'b0;
    end else begin
      state <= state_next;
      seg_q <= seg_in;
      if (moving)
        cnt <= '0;
      else if (!stable)
        cnt <= cnt + 1'b1;
      if (load) begin
        last_pat  <= seg_q;
        have_last <= 1'b1;
      end
    end
  end

  // Report outputs change only on load, so they stay frozen while a report is pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_o   <= '0;
      blank_o   <= 1'b0;
      invalid_o <= 1'b0;
      ambig_o   <= 1'b0;
      valid_o   <= 1'b0;
    end else begin
      if (load) begin
        value_o   <= {seg_q[7], dec_digit};
        blank_o   <= dec_blank;
        invalid_o <= dec_invalid;
        ambig_o   <= dec_ambig;
        valid_o   <= 1'b1;
      end else if (ack) begin
        valid_o <= 1'b0;
      end
    end
  end

  // Set has priority over clear so a simultaneous overrun is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n)
      overrun_o <= 1'b0;
    else if (state == HOLD && moving)
      overrun_o <= 1'b1;
    else if (clr_i)
      overrun_o <= 1'b0;
  end

endmodule
